// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with a fixed
// response latency, RISC-V byte/half/word sizing and sign/zero extension.
// Optional build macro DMEM_MISALIGN_CHECK_EN rejects misaligned half/word
// accesses; without it the low address bits are forced to alignment.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LatCnt = 4'(LATENCY);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          accept, enter_resp;

  logic          write_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [2:0]    func3_q;

  logic          op_write;
  logic [AW+1:0] op_addr;
  logic [31:0]   op_wdata;
  logic [2:0]    op_func3;
  logic [AW-1:0] op_idx;

  logic          func_ok, err;
  logic [31:0]   rd_word, rd_shift, load_data, merged, wd;
  logic [15:0]   rd_half;
  logic [3:0]    be;

  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // Next-state, wait counter and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    req_ready = (state_q == StIdle);
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (LatCnt == 4'd0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = LatCnt;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign enter_resp = (state_q != StResp) && (state_d == StResp);

  // With zero latency the operation executes on the accept edge itself,
  // so the live request fields are used while idle.
  always_comb begin
    op_write = write_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_func3 = func3_q;
    if (state_q == StIdle) begin
      op_write = req_write;
      op_addr  = req_addr[AW+1:0];
      op_wdata = req_wdata;
      op_func3 = req_func3;
    end
  end

  assign op_idx = op_addr[AW+1:2];

  // Legal func3 decode plus optional alignment check.
  always_comb begin
    if (op_write) begin
      func_ok = (op_func3 == 3'b000) || (op_func3 == 3'b001) || (op_func3 == 3'b010);
    end else begin
      func_ok = (op_func3 == 3'b000) || (op_func3 == 3'b001) || (op_func3 == 3'b010) ||
                (op_func3 == 3'b100) || (op_func3 == 3'b101);
    end
`ifdef DMEM_MISALIGN_CHECK_EN
    unique case (op_func3[1:0])
      2'b01:   err = !func_ok || op_addr[0];
      2'b10:   err = !func_ok || (op_addr[1:0] != 2'b00);
      default: err = !func_ok;
    endcase
`else
    err = !func_ok;
`endif
  end

  // Load extraction and store lane merge; half uses addr[1], word ignores [1:0].
  always_comb begin
    rd_word   = mem[op_idx];
    rd_shift  = rd_word >> {op_addr[1:0], 3'b000};
    rd_half   = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'd0;
    be        = 4'b0000;
    wd        = op_wdata;
    unique case (op_func3)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_data = {24'd0, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_data = {16'd0, rd_half};
      3'b010:  load_data = rd_word;
      default: load_data = 32'd0;
    endcase
    unique case (op_func3)
      3'b000: begin
        be = 4'b0001 << op_addr[1:0];
        wd = {4{op_wdata[7:0]}};
      end
      3'b001: begin
        be = op_addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{op_wdata[15:0]}};
      end
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
  end

  // FSM state and response registers; response captured on the RESP entry edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rsp_rdata_q <= (op_write || err) ? 32'd0 : load_data;
        rsp_err_q   <= err;
      end
    end
  end

  // Request fields held for the duration of the transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
      func3_q <= req_func3;
    end
  end

  // Storage array; not reset, stores commit only on the RESP entry edge.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && op_write && !err) begin
      mem[op_idx] <= merged;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256) with an
// expected-response queue filled at request time and drained at response time.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks   = 0;
  int failures = 0;
  logic [32:0] sb_q[$];

  dmem_responder #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_func3(req_func3),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and follow it to the response handshake.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err, input int stall);
    logic [32:0] e;
    logic [31:0] held;
    sb_q.push_back({exp_err, exp_rd});
    check({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    rsp_ready = 1'b0;
    step();
    // Garbage store presented while busy must be ignored.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0BAD0BAD;
    req_func3 = 3'b010;
    for (int i = 0; i < LAT; i++) begin
      check({tag, "_wait_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_wait_ready"}, 32'(req_ready), 32'd0);
      step();
    end
    req_valid = 1'b0;
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e[31:0]);
      check({tag, "_err"}, 32'(rsp_err), 32'(e[32]));
    end
    held = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      step();
      check({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_stall_rdata"}, rsp_rdata, held);
      check({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    check({tag, "_hs_ready"}, 32'(req_ready), 32'd0);
    step();
    rsp_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] lh13_rd, w10;
    logic        mis_err;
`ifdef DMEM_MISALIGN_CHECK_EN
    lh13_rd = 32'h0000_0000; mis_err = 1'b1; w10 = 32'h8001_80EF;
`else
    lh13_rd = 32'hFFFF_8001; mis_err = 1'b0; w10 = 32'hCAFE_F00D;
`endif
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_func3 = '0; rsp_ready = 1'b0;
    step(); step();
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);

    do_req("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0, 0);
    do_req("lw10", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0, 0);
    do_req("sb11", 1'b1, 32'h11, 32'h1234_5680, 3'b000, 32'h0, 1'b0, 0);
    do_req("lb11", 1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0, 0);
    do_req("lbu11", 1'b0, 32'h11, 32'h0, 3'b100, 32'h0000_0080, 1'b0, 0);
    do_req("lw10b", 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_80EF, 1'b0, 0);
    do_req("sh12", 1'b1, 32'h12, 32'hFFFF_8001, 3'b001, 32'h0, 1'b0, 0);
    do_req("lw10c", 1'b0, 32'h10, 32'h0, 3'b010, 32'h8001_80EF, 1'b0, 0);
    do_req("lh12", 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_8001, 1'b0, 0);
    do_req("lhu12", 1'b0, 32'h12, 32'h0, 3'b101, 32'h0000_8001, 1'b0, 0);
    do_req("lh13", 1'b0, 32'h13, 32'h0, 3'b001, lh13_rd, mis_err, 0);
    do_req("lbu12", 1'b0, 32'h12, 32'h0, 3'b100, 32'h0000_0001, 1'b0, 0);
    do_req("ld011", 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0);
    do_req("st100", 1'b1, 32'h10, 32'h0, 3'b100, 32'h0, 1'b1, 0);
    do_req("lw10d", 1'b0, 32'h10, 32'h0, 3'b010, 32'h8001_80EF, 1'b0, 0);
    do_req("sw11", 1'b1, 32'h11, 32'hCAFE_F00D, 3'b010, 32'h0, mis_err, 0);
    do_req("lw_stall", 1'b0, 32'h10, 32'h0, 3'b010, w10, 1'b0, 5);

    // Store aborted by reset while waiting must not commit.
    do_req("sw20", 1'b1, 32'h20, 32'h1111_1111, 3'b010, 32'h0, 1'b0, 0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234_5678;
    req_func3 = 3'b010;
    step();
    req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    step();
    check("abort_valid2", 32'(rsp_valid), 32'd0);
    do_req("lw20", 1'b0, 32'h20, 32'h0, 3'b010, 32'h1111_1111, 1'b0, 0);

    do_req("sw400", 1'b1, 32'h400, 32'hA5A5_A5A5, 3'b010, 32'h0, 1'b0, 0);
    do_req("lw0", 1'b0, 32'h0, 32'h0, 3'b010, 32'hA5A5_A5A5, 1'b0, 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
